clken_sel: RTL and testbench
============================

# clken_sel

Selectable-rate clock-enable generator for the TD4 core. It produces a one-cycle `en` pulse that advances the CPU in one of four modes: slow periodic, fast periodic, manual single-step from a debounced push button, or halt. The block sits between the board clock/switches and the CPU, and is the parametrised successor of the fixed 1 Hz enable divider. The CPU register enables are driven directly from `en`.

## Interface
- `DIV_SLOW`, default 50_000_000: slow-mode period in `clk` cycles; must be ≥ 2.
- `DIV_FAST`, default 5_000_000: fast-mode period in `clk` cycles; must be ≥ 2.
- `DEB`, default 500_000: debounce window in `clk` cycles; must be ≥ 1.
- `clk` in 1: single system clock, rising edge.
- `clr_n` in 1: reset, asynchronous, active-low.
- `mode` in 2: raw switch input; 00 slow, 01 fast, 10 manual, 11 halt. Asynchronous to `clk`.
- `step_n` in 1: raw push button, active-low, bouncing, asynchronous.
- `en` out 1: registered enable pulse, high for exactly one `clk` cycle.
- `mode_q` out 2: currently active mode.
- `step_db` out 1: debounced button level, active-low; drives an LED.

## Operation
- **Reset.** While `clr_n` = 0, all flops clear immediately:
  - `en` = 0, `mode_q` = 00, `step_db` = 1, counters = 0.
  - The mode synchronisers reset to 00 and the button synchronisers reset to 1.
- **Mode path.**
  - `mode` passes through a 2-flop synchroniser into `mode_s`.
  - Each edge, `mode_q <= mode_s`.
  - On any edge where `mode_s != mode_q`: the period counter clears to 0 and `en` is 0.
- **Periodic modes (00/01).**
  - `cnt` increments each cycle.
  - When `cnt == DIV-1` (DIV is the period of the active mode): `cnt <= 0` and `en <= 1`; otherwise `en <= 0`.
  - `cnt` width is `$clog2(max(DIV_SLOW, DIV_FAST))`. `cnt` never exceeds DIV-1.
- **Manual mode (10).**
  - `step_n` passes through a 2-flop synchroniser into `step_s`.
  - Debouncer: `dcnt` counts consecutive cycles with `step_s != step_db`, and clears whenever they are equal.
  - When `dcnt == DEB-1` and they still differ: `step_db <= step_s` and `dcnt <= 0`.
  - `en <= 1` for one cycle on a 1→0 transition of `step_db`, only while `mode_q == 10`.
  - A release (0→1) never pulses. `cnt` is held at 0.
- **Halt (11).** `en` = 0 and `cnt` is held at 0.
- **Debouncer in other modes.** The debouncer runs in every mode. A fall of `step_db` outside manual mode is discarded.
- **Entering manual mode with the button held.** No pulse is produced; a pulse requires a fresh press.
- **Simultaneous events.** Mode-change clearing has priority over a period wrap or a button edge in the same cycle: no pulse is produced.

## Timing
- **Periodic modes.** First `en` after reset release (mode stable) is high in the cycle following edge DIV, where edge 1 is the first edge with `clr_n` = 1. Subsequent pulses follow every DIV cycles, with no jitter.
- **Mode switch latency.**
  - `mode_q` updates 3 edges after `mode` changes (2 sync + 1).
  - The first pulse in the new periodic mode comes DIV edges after the `mode_q` update.
- **Manual press latency.** Let edge k be the first edge at which the first synchroniser flop samples 0 on a clean press.
  - `step_db` falls at edge k+1+DEB.
  - `en` is high in the cycle after edge k+2+DEB.
- **Reset mid-operation.**
  - `en` drops asynchronously on `clr_n` falling.
  - After release, counting restarts from 0 in mode 00 until the synchronised mode propagates.

## Structure
- **Shared package `td4_clk_pkg`:**
  - Mode constants `MODE_SLOW`, `MODE_FAST`, `MODE_STEP`, `MODE_HALT` (2 bits).
  - Default divider and debounce constants for the 50 MHz board.
- **Sub-module `btn_debounce` #(DEB):**
  - Ports: `clk`, `clr_n`, `btn_n`, `db_n`, `fall`.
  - Contains the 2-flop synchroniser, `dcnt` and the edge detector.
- **Top level:** mode synchroniser, period counter, mode-change clearing and `en` register.
- **Elaboration check:** parameter ranges are checked at elaboration; out-of-range values are an error.

## Test plan
Bench parameters: `DIV_SLOW`=8, `DIV_FAST`=4, `DEB`=4; clock period 20.
1. **Slow periodic.** `clr_n` low for 2 cycles, `mode`=00 held → `en` pulses in cycles 8, 16, 24 after release, each 1 cycle wide. No pulse while `clr_n` = 0.
2. **Fast periodic.** `mode`=01 from reset → `mode_q`=01 at edge 3, then pulses every 4 cycles. `cnt` never reaches 4.
3. **Mid-count switch.** Slow mode with `cnt`=5, switch `mode` to 01 → no pulse at the switch. `cnt` clears when `mode_q` changes. Next pulse 4 cycles later.
4. **Bouncing press.** Manual mode; `step_n` low 2 cycles, high 1 cycle, low 12 cycles, high 12 cycles → exactly one `en` pulse, at k+2+DEB relative to the final fall. `step_db` shows a single low interval. No pulse on release.
5. **Halt.** `mode`=11 for 100 cycles with button presses → `en` stays 0. `step_db` still follows the debounced button.
6. **Reset mid-pulse / held button.**
   - Assert `clr_n` in the cycle `en` is high → `en` drops at once, and counting restarts from 0 after release.
   - Switch to manual with the button held → no pulse.

Source files
------------

// File: rtl/td4_clk_pkg.sv
// Shared definitions for the TD4 clock-enable logic: mode encodings and
// default timing constants for the 50 MHz board.
package td4_clk_pkg;

    localparam logic [1:0] MODE_SLOW = 2'b00;
    localparam logic [1:0] MODE_FAST = 2'b01;
    localparam logic [1:0] MODE_STEP = 2'b10;
    localparam logic [1:0] MODE_HALT = 2'b11;

    localparam int unsigned DIV_SLOW_50M = 50_000_000;
    localparam int unsigned DIV_FAST_50M = 5_000_000;
    localparam int unsigned DEB_50M      = 500_000;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser, consecutive-cycle debouncer and
// a one-cycle pulse on each debounced press (1 -> 0 of the active-low level).
module btn_debounce #(
    parameter int unsigned DEB = 500_000
) (
    input  logic clk,
    input  logic clr_n,
    input  logic btn_n,
    output logic db_n,
    output logic fall
);

    localparam int unsigned   DW    = (DEB > 1) ? $clog2(DEB) : 1;
    localparam logic [DW-1:0] DLAST = DW'(DEB - 1);

    logic          sync1;
    logic          btn_s;
    logic          db_prev;
    logic [DW-1:0] dcnt;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            sync1 <= 1'b1;
            btn_s <= 1'b1;
        end else begin
            sync1 <= btn_n;
            btn_s <= sync1;
        end
    end

    // The level only moves after DEB consecutive cycles of disagreement.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            dcnt    <= '0;
            db_n    <= 1'b1;
            db_prev <= 1'b1;
        end else begin
            db_prev <= db_n;
            if (btn_s == db_n) begin
                dcnt <= '0;
            end else if (dcnt == DLAST) begin
                db_n <= btn_s;
                dcnt <= '0;
            end else begin
                dcnt <= dcnt + DW'(1);
            end
        end
    end

    assign fall = db_prev & ~db_n;

endmodule

// File: rtl/clken_sel.sv
// Selectable-rate CPU clock enable: slow/fast periodic, manual single-step
// from the debounced button, or halt.
module clken_sel
    import td4_clk_pkg::*;
#(
    parameter int unsigned DIV_SLOW = DIV_SLOW_50M,
    parameter int unsigned DIV_FAST = DIV_FAST_50M,
    parameter int unsigned DEB      = DEB_50M
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic [1:0] mode,
    input  logic       step_n,
    output logic       en,
    output logic [1:0] mode_q,
    output logic       step_db
);

    localparam int unsigned   CW        = $clog2(max_u(DIV_SLOW, DIV_FAST));
    localparam logic [CW-1:0] SLOW_LAST = CW'(DIV_SLOW - 1);
    localparam logic [CW-1:0] FAST_LAST = CW'(DIV_FAST - 1);

    if (DIV_SLOW < 2) begin : g_bad_div_slow
        $error("clken_sel: DIV_SLOW must be at least 2");
    end
    if (DIV_FAST < 2) begin : g_bad_div_fast
        $error("clken_sel: DIV_FAST must be at least 2");
    end
    if (DEB < 1) begin : g_bad_deb
        $error("clken_sel: DEB must be at least 1");
    end

    logic [1:0]    mode_m;
    logic [1:0]    mode_s;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_d;
    logic [CW-1:0] last;
    logic          en_d;
    logic          fall;

    btn_debounce #(
        .DEB (DEB)
    ) u_btn_debounce (
        .clk   (clk),
        .clr_n (clr_n),
        .btn_n (step_n),
        .db_n  (step_db),
        .fall  (fall)
    );

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            mode_m <= MODE_SLOW;
            mode_s <= MODE_SLOW;
            mode_q <= MODE_SLOW;
        end else begin
            mode_m <= mode;
            mode_s <= mode_m;
            mode_q <= mode_s;
        end
    end

    // A pending mode change wins over a wrap or a button edge in the same cycle.
    always_comb begin
        cnt_d = '0;
        en_d  = 1'b0;
        last  = (mode_q == MODE_FAST) ? FAST_LAST : SLOW_LAST;
        if (mode_s == mode_q) begin
            case (mode_q)
                MODE_SLOW, MODE_FAST: begin
                    if (cnt == last) begin
                        en_d = 1'b1;
                    end else begin
                        cnt_d = cnt + CW'(1);
                    end
                end
                MODE_STEP: en_d = fall;
                default:   en_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            cnt <= '0;
            en  <= 1'b0;
        end else begin
            cnt <= cnt_d;
            en  <= en_d;
        end
    end

endmodule

// File: tb/tb_clken_sel.sv
// Randomised scoreboard bench for clken_sel against a window-based reference model.
`timescale 1ns/1ps
module tb_clken_sel;
    import td4_clk_pkg::*;

    localparam int DIV_SLOW = 8;
    localparam int DIV_FAST = 4;
    localparam int DEB      = 4;
    localparam int MAXE     = 8192;

    logic       clk    = 1'b0;
    logic       clr_n  = 1'b0;
    logic [1:0] mode   = MODE_SLOW;
    logic       step_n = 1'b1;
    logic       en;
    logic [1:0] mode_q;
    logic       step_db;

    clken_sel #(
        .DIV_SLOW (DIV_SLOW),
        .DIV_FAST (DIV_FAST),
        .DEB      (DEB)
    ) dut (
        .clk     (clk),
        .clr_n   (clr_n),
        .mode    (mode),
        .step_n  (step_n),
        .en      (en),
        .mode_q  (mode_q),
        .step_db (step_db)
    );

    always #10 clk = ~clk;

    int         errors = 0;
    int         checks = 0;
    int         pulses = 0;
    int         db_falls = 0;
    int         ecnt = 0;
    int         seg = 0;
    logic [1:0] mq_m = MODE_SLOW;
    logic       db_m = 1'b1;
    logic       db_mon_prev = 1'b1;
    logic [1:0] mraw [MAXE];
    logic       sraw [MAXE];
    logic       dbh  [MAXE];
    int         exp_q [$];

    // Edge j is the j-th rising edge after reset release; raw values are what the
    // first synchroniser flop sampled there. Before edge 1 the reset values apply.
    function automatic logic [1:0] mode_at(int j);
        return (j < 1) ? MODE_SLOW : mraw[j];
    endfunction

    function automatic logic step_at(int j);
        return (j < 1) ? 1'b1 : sraw[j];
    endfunction

    function automatic logic db_at(int j);
        return (j < 1) ? 1'b1 : dbh[j];
    endfunction

    // Reference model: active mode lags raw mode by two edges; the debounced level
    // flips once the last DEB synchronised samples all disagree with it; pulses
    // fall on period multiples from the last mode change or one edge after a fall.
    always @(posedge clk) begin
        logic [1:0] mq_prev;
        logic       chg;
        logic       flip;
        int         div;
        if (!clr_n) begin
            ecnt = 0;
            seg  = 0;
            mq_m = MODE_SLOW;
            db_m = 1'b1;
            exp_q.delete();
        end else if (ecnt < MAXE - 1) begin
            ecnt = ecnt + 1;
            mraw[ecnt] = mode;
            sraw[ecnt] = step_n;
            mq_prev = mq_m;
            mq_m    = mode_at(ecnt - 2);
            chg     = (mq_m != mq_prev);
            flip = 1'b1;
            for (int j = ecnt - 1 - DEB; j <= ecnt - 2; j++) begin
                if (step_at(j) == db_at(ecnt - 1)) flip = 1'b0;
            end
            dbh[ecnt] = flip ? ~db_at(ecnt - 1) : db_at(ecnt - 1);
            db_m = dbh[ecnt];
            div  = (mq_prev == MODE_FAST) ? DIV_FAST : DIV_SLOW;
            if (chg) begin
                seg = ecnt;
            end else if ((mq_prev == MODE_SLOW || mq_prev == MODE_FAST) &&
                         ((ecnt - seg) % div == 0)) begin
                exp_q.push_back(ecnt);
            end else if (mq_prev == MODE_STEP && db_at(ecnt - 2) && !db_at(ecnt - 1)) begin
                exp_q.push_back(ecnt);
            end
        end
    end

    // Monitor: pops an expected pulse whenever en is presented.
    always @(negedge clk) begin
        int tmp;
        if (!clr_n) begin
            db_mon_prev = 1'b1;
            checks = checks + 1;
            if (en !== 1'b0 || mode_q !== MODE_SLOW || step_db !== 1'b1) begin
                errors = errors + 1;
                $display("FAIL reset_state: en=%b mode_q=%b step_db=%b, required 0 00 1",
                         en, mode_q, step_db);
            end
        end else begin
            checks = checks + 1;
            if (en === 1'b1) begin
                pulses = pulses + 1;
                if (exp_q.size() > 0 && exp_q[0] == ecnt) begin
                    tmp = exp_q.pop_front();
                end else begin
                    errors = errors + 1;
                    $display("FAIL en_pulse: en=1 after edge %0d, required 0", ecnt);
                end
            end else if (exp_q.size() > 0 && exp_q[0] == ecnt) begin
                tmp = exp_q.pop_front();
                errors = errors + 1;
                $display("FAIL en_pulse: en=%b after edge %0d, required 1", en, ecnt);
            end
            checks = checks + 1;
            if (mode_q !== mq_m) begin
                errors = errors + 1;
                $display("FAIL mode_q: got %b after edge %0d, required %b", mode_q, ecnt, mq_m);
            end
            checks = checks + 1;
            if (step_db !== db_m) begin
                errors = errors + 1;
                $display("FAIL step_db: got %b after edge %0d, required %b", step_db, ecnt, db_m);
            end
            if (db_mon_prev && !step_db) db_falls = db_falls + 1;
            db_mon_prev = step_db;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic ticks(int n);
        repeat (n) tick();
    endtask

    task automatic check(bit ok, string name, int act, int req);
        checks = checks + 1;
        if (!ok) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic do_reset(logic [1:0] m, int n);
        tick();
        clr_n  = 1'b0;
        mode   = m;
        step_n = 1'b1;
        ticks(n);
        clr_n = 1'b1;
    endtask

    task automatic wait_en(int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            @(posedge clk);
            #5;
            if (en === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        int d0;
        bit ok;

        // Slow periodic from reset.
        do_reset(MODE_SLOW, 2);
        p0 = pulses;
        ticks(30);
        check(pulses - p0 == 3, "slow_pulse_count", pulses - p0, 3);

        // Fast periodic from reset.
        do_reset(MODE_FAST, 2);
        p0 = pulses;
        ticks(21);
        check(pulses - p0 == 4, "fast_pulse_count", pulses - p0, 4);

        // Switch to fast with the slow counter at 5; the clear hits a would-be wrap.
        do_reset(MODE_SLOW, 2);
        ticks(5);
        mode = MODE_FAST;
        p0 = pulses;
        ticks(20);
        check(pulses - p0 == 4, "switch_pulse_count", pulses - p0, 4);

        // Bouncing press in manual mode.
        do_reset(MODE_STEP, 2);
        ticks(6);
        p0 = pulses;
        d0 = db_falls;
        step_n = 1'b0; ticks(2);
        step_n = 1'b1; ticks(1);
        step_n = 1'b0; ticks(12);
        step_n = 1'b1; ticks(12);
        check(pulses - p0 == 1, "bounce_pulse_count", pulses - p0, 1);
        check(db_falls - d0 == 1, "bounce_db_low_intervals", db_falls - d0, 1);

        // Halt with button activity.
        mode = MODE_HALT;
        ticks(4);
        p0 = pulses;
        d0 = db_falls;
        step_n = 1'b0; ticks(20);
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 5) == 0) step_n = ~step_n;
            tick();
        end
        check(pulses - p0 == 0, "halt_pulse_count", pulses - p0, 0);
        check(db_falls - d0 >= 1, "halt_db_follows", db_falls - d0, 1);
        step_n = 1'b1;
        ticks(10);

        // Reset while en is high.
        mode = MODE_SLOW;
        wait_en(40, ok);
        check(ok, "wait_en_before_reset", int'(ok), 1);
        if (ok) begin
            clr_n = 1'b0;
            #1;
            check(en === 1'b0, "async_en_drop", int'(en), 0);
            ticks(2);
            clr_n = 1'b1;
            p0 = pulses;
            ticks(17);
            check(pulses - p0 == 2, "post_reset_pulse_count", pulses - p0, 2);
        end

        // Enter manual mode with the button already held.
        step_n = 1'b0;
        ticks(12);
        mode = MODE_STEP;
        ticks(4);
        p0 = pulses;
        ticks(16);
        check(pulses - p0 == 0, "held_entry_no_pulse", pulses - p0, 0);
        step_n = 1'b1; ticks(12);
        step_n = 1'b0; ticks(12);
        check(pulses - p0 == 1, "fresh_press_pulse", pulses - p0, 1);
        step_n = 1'b1;
        ticks(10);

        // Random modes and button activity.
        do_reset(MODE_SLOW, 2);
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 24) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 5) == 0) step_n = ~step_n;
            tick();
        end
        ticks(5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
